// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// The arbiter uses the slave side; the requesting environment uses master.
interface rr_grant_arbiter_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Eight-way round-robin arbiter with registered one-hot grant,
// hold-limit timeout and a one-cycle turnaround gap between grants.
module rr_grant_arbiter #(
  parameter int N_REQ    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               reset,
  rr_grant_arbiter_if.slave  bus
);

  localparam int IW = 3;
  localparam int CW = $clog2(MAX_HOLD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q, timeout_d;

  logic             win_found;
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    cand;
  logic             owner_req;
  logic             hold_done;

  // Scan downward so the lowest offset from ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr_q + IW'(k);
      if (bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign owner_req = bus.req[gnt_idx_q];
  assign hold_done = (cnt_q == CW'(MAX_HOLD - 1));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    unique case (state_q)
      S_IDLE, S_GAP: begin
        if (win_found) begin
          state_d     = S_GRANT;
          gnt_d       = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          gnt_idx_d   = win_idx;
          gnt_valid_d = 1'b1;
          cnt_d       = '0;
        end else begin
          state_d     = S_IDLE;
          gnt_d       = '0;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
        end
      end
      S_GRANT: begin
        if (!owner_req || hold_done) begin
          state_d     = S_GAP;
          gnt_d       = '0;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_idx_q + IW'(1);
          timeout_d   = owner_req;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d     = S_IDLE;
        gnt_d       = '0;
        gnt_idx_d   = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;

  a_onehot: assert property (
    @(posedge clk) disable iff (reset) $onehot0(gnt_q));
  a_valid: assert property (
    @(posedge clk) disable iff (reset) gnt_valid_q == (|gnt_q));
  a_to_excl: assert property (
    @(posedge clk) disable iff (reset) !(timeout_q && gnt_valid_q));

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Randomised and directed bench for rr_grant_arbiter against an
// owner/hold-count reference model.
module tb_rr_grant_arbiter;

  localparam int MAXH = 16;

  logic clk = 1'b0;
  logic reset;

  rr_grant_arbiter_if bus ();

  rr_grant_arbiter #(
    .N_REQ(8),
    .MAX_HOLD(MAXH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: current owner (-1 none), cycles held, priority start
  int m_owner;
  int m_held;
  int m_ptr;
  bit m_to;

  logic [7:0] prev_gnt;
  logic       prev_valid;
  int         run_len;

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_owner    = -1;
    m_held     = 0;
    m_ptr      = 0;
    m_to       = 1'b0;
    prev_gnt   = '0;
    prev_valid = 1'b0;
    run_len    = 0;
  endfunction

  function automatic void m_step(logic [7:0] r);
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_to    = 1'b0;
      end else if (m_held == MAXH) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_to    = 1'b1;
      end else begin
        m_held++;
        m_to = 1'b0;
      end
    end else begin
      m_to = 1'b0;
      for (int k = 0; k < 8; k++) begin
        int i;
        i = (m_ptr + k) % 8;
        if (r[i]) begin
          m_owner = i;
          m_held  = 1;
          break;
        end
      end
    end
  endfunction

  task automatic compare();
    int eg;
    int ei;
    eg = (m_owner >= 0) ? (1 << m_owner) : 0;
    ei = (m_owner >= 0) ? m_owner : 0;
    chk("gnt", int'(bus.gnt), eg);
    chk("gnt_idx", int'(bus.gnt_idx), ei);
    chk("gnt_valid", int'(bus.gnt_valid), int'(m_owner >= 0));
    chk("timeout", int'(bus.timeout), int'(m_to));
    chk("onehot0", int'($onehot0(bus.gnt)), 1);
    chk("valid_eq_or", int'(bus.gnt_valid), int'(|bus.gnt));
    chk("to_vs_valid", int'(bus.timeout && bus.gnt_valid), 0);
    if (bus.gnt_valid) begin
      chk("gnt_at_idx", int'(bus.gnt[bus.gnt_idx]), 1);
      if (prev_valid)
        chk("no_gap", int'(bus.gnt), int'(prev_gnt));
      run_len = (prev_valid && bus.gnt == prev_gnt) ? run_len + 1 : 1;
      chk("hold_len", int'(run_len <= MAXH), 1);
    end else begin
      run_len = 0;
    end
    prev_gnt   = bus.gnt;
    prev_valid = bus.gnt_valid;
  endtask

  // Called at a negedge; applies r, crosses one rising edge, checks.
  task automatic cyc(logic [7:0] r);
    bus.req = r;
    @(posedge clk);
    m_step(r);
    #1;
    compare();
    @(negedge clk);
  endtask

  // Called at a negedge; asserts reset between edges to test async clear.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_gnt", int'(bus.gnt), 0);
    chk("rst_valid", int'(bus.gnt_valid), 0);
    chk("rst_idx", int'(bus.gnt_idx), 0);
    chk("rst_timeout", int'(bus.timeout), 0);
    @(negedge clk);
    reset = 1'b0;
    m_reset();
  endtask

  initial begin
    logic [7:0] r;
    reset   = 1'b1;
    bus.req = '0;
    m_reset();
    @(negedge clk);
    @(negedge clk);

    // idle then single request
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(8'h00);
      chk("idle_gnt", int'(bus.gnt), 0);
    end
    cyc(8'h10);
    chk("first_gnt", int'(bus.gnt), 8'h10);
    chk("first_idx", int'(bus.gnt_idx), 4);
    for (int i = 0; i < 3; i++) cyc(8'h00);

    // all requesting: timeouts rotate 0..7 then wrap to 0
    do_reset();
    for (int c = 1; c <= 137; c++) begin
      cyc(8'hFF);
      if ((c - 1) % 17 == 0) begin
        chk("rot_idx", int'(bus.gnt_idx), ((c - 1) / 17) % 8);
        chk("rot_valid", int'(bus.gnt_valid), 1);
      end
      if (c % 17 == 0) begin
        chk("rot_timeout", int'(bus.timeout), 1);
        chk("rot_gap", int'(bus.gnt), 0);
      end
    end

    // release ordering 0 -> 7 -> 0
    do_reset();
    cyc(8'h81);
    chk("r81_first", int'(bus.gnt), 8'h01);
    cyc(8'h81);
    cyc(8'h81);
    cyc(8'h80);
    chk("r81_gap", int'(bus.gnt), 0);
    chk("r81_gap_to", int'(bus.timeout), 0);
    cyc(8'h80);
    chk("r81_g7", int'(bus.gnt), 8'h80);
    cyc(8'h01);
    chk("r81_gap2", int'(bus.gnt), 0);
    cyc(8'h01);
    chk("r81_g0", int'(bus.gnt), 8'h01);

    // other requests ignored during a grant; pointer follows release
    do_reset();
    cyc(8'h04);
    chk("g2", int'(bus.gnt), 8'h04);
    cyc(8'h24);
    cyc(8'h24);
    chk("g2_hold", int'(bus.gnt), 8'h04);
    cyc(8'h04);
    cyc(8'h48);
    chk("g2_rel", int'(bus.gnt), 0);
    cyc(8'h48);
    chk("g3", int'(bus.gnt), 8'h08);
    chk("g3_idx", int'(bus.gnt_idx), 3);

    // async reset mid-hold, pointer restarts at 0
    do_reset();
    cyc(8'h20);
    cyc(8'h20);
    cyc(8'h20);
    chk("g5", int'(bus.gnt), 8'h20);
    bus.req = 8'h21;
    do_reset();
    cyc(8'h21);
    chk("post_rst", int'(bus.gnt), 8'h01);

    // randomised traffic
    r = '0;
    for (int c = 0; c < 10000; c++) begin
      int mode;
      mode = $urandom_range(0, 99);
      if (mode < 3) r = 8'($urandom);
      else if (mode < 5) r = 8'hFF;
      else begin
        for (int b = 0; b < 8; b++)
          if ($urandom_range(0, 15) == 0) r[b] = ~r[b];
      end
      cyc(r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
